// File: rtl/br_pred_pkg.sv
// br_pred_pkg: shared types, defaults and saturating arithmetic for the branch predictor
package br_pred_pkg;
  typedef enum logic {BP_BIMODAL, BP_GSHARE} bp_mode_t;
  localparam int DEF_PC_W = 32;
  localparam int DEF_IDX_W = 6;
  localparam int DEF_CNT_W = 2;
  localparam int DEF_HIST_W = 4;
  localparam int DEF_STAT_W = 16;
  localparam bp_mode_t DEF_MODE = BP_GSHARE;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return v >= max ? max : v + 32'd1;
  endfunction
  function automatic logic [31:0] sat_dec(input logic [31:0] v);
    return v == 32'd0 ? v : v - 32'd1;
  endfunction
endpackage

// File: rtl/br_sat_ctr.sv
// br_sat_ctr: one saturating up/down counter, MSB gives the predicted direction
module br_sat_ctr
  import br_pred_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int RST_CNT = 2**CNT_W-1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic dec_i,
  output logic msb_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb
    cnt_d = inc_i ? CNT_W'(sat_inc(32'(cnt_q), 32'(CNT_MAX)))
          : dec_i ? CNT_W'(sat_dec(32'(cnt_q))) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= CNT_W'(RST_CNT);
    else cnt_q <= cnt_d;
  assign msb_o = cnt_q[CNT_W-1];
endmodule

// File: rtl/br_predict_table.sv
// br_predict_table: bimodal/gshare direction predictor with a saturating mispredict counter
module br_predict_table
  import br_pred_pkg::*;
#(
  parameter int       PC_W    = DEF_PC_W,
  parameter int       IDX_W   = DEF_IDX_W,
  parameter int       CNT_W   = DEF_CNT_W,
  parameter int       HIST_W  = DEF_HIST_W,
  parameter bp_mode_t MODE    = DEF_MODE,
  parameter int       RST_CNT = 2**CNT_W-1,
  parameter int       STAT_W  = DEF_STAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pred_valid_i,
  input  logic [PC_W-1:0]   pred_pc_i,
  output logic              pred_valid_o,
  output logic              pred_take_o,
  output logic [IDX_W-1:0]  pred_idx_o,
  input  logic              upd_valid_i,
  input  logic [IDX_W-1:0]  upd_idx_i,
  input  logic              upd_taken_i,
  input  logic              upd_pred_i,
  input  logic              flush_i,
  output logic [STAT_W-1:0] mispred_cnt_o
);
  localparam int ENTRIES = 2**IDX_W;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;
  logic [ENTRIES-1:0] msb;
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [IDX_W-1:0] idx, pred_idx_q, pred_idx_d;
  logic pred_valid_q, pred_valid_d, pred_take_q, pred_take_d;
  logic [STAT_W-1:0] mispred_q, mispred_d;
  logic lookup;
  logic unused_pc;
  assign unused_pc = ^{pred_pc_i[PC_W-1:IDX_W+2], pred_pc_i[1:0]};
  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    br_sat_ctr #(.CNT_W(CNT_W), .RST_CNT(RST_CNT)) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (upd_valid_i && upd_idx_i == IDX_W'(g) && upd_taken_i),
      .dec_i (upd_valid_i && upd_idx_i == IDX_W'(g) && !upd_taken_i),
      .msb_o (msb[g])
    );
  end
  // Lookup sees pre-update table and history; a flushed lookup is dropped and outputs hold.
  always_comb begin
    idx = pred_pc_i[IDX_W+1:2] ^ (MODE == BP_GSHARE ? IDX_W'(ghr_q) : '0);
    lookup = pred_valid_i && !flush_i;
    pred_valid_d = lookup;
    pred_take_d = lookup ? msb[idx] : pred_take_q;
    pred_idx_d = lookup ? idx : pred_idx_q;
    ghr_d = flush_i ? '0 : upd_valid_i ? HIST_W'({ghr_q, upd_taken_i}) : ghr_q;
    mispred_d = (upd_valid_i && upd_pred_i != upd_taken_i)
              ? STAT_W'(sat_inc(32'(mispred_q), 32'(STAT_MAX))) : mispred_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ghr_q <= '0;
      pred_valid_q <= 1'b0;
      pred_take_q <= 1'b0;
      pred_idx_q <= '0;
      mispred_q <= '0;
    end else begin
      ghr_q <= ghr_d;
      pred_valid_q <= pred_valid_d;
      pred_take_q <= pred_take_d;
      pred_idx_q <= pred_idx_d;
      mispred_q <= mispred_d;
    end
  assign pred_valid_o = pred_valid_q;
  assign pred_take_o = pred_take_q;
  assign pred_idx_o = pred_idx_q;
  assign mispred_cnt_o = mispred_q;
endmodule

// File: tb/tb_br_predict_table.sv
// tb_br_predict_table: gshare and bimodal instances on shared stimulus, checked against a table model
module tb_br_predict_table;
  import br_pred_pkg::*;
  logic clk = 0, rst_n = 0;
  logic pred_valid_i = 0, upd_valid_i = 0, upd_taken_i = 0, upd_pred_i = 0, flush_i = 0;
  logic [31:0] pred_pc_i = 0;
  logic [5:0] upd_idx_i = 0;
  logic pv_a, pt_a, pv_b, pt_b;
  logic [5:0] pi_a, pi_b;
  logic [15:0] mc_a;
  logic [1:0] mc_b;
  int total = 0, passed = 0;
  int ca[64], cb[64];
  int ghr, eta, etb, eia, eib, sa, sb, mia, mib;
  bit ev;

  always #5 clk = ~clk;

  br_predict_table #(.MODE(BP_GSHARE)) u_a (
    .clk(clk), .rst_n(rst_n), .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i),
    .pred_valid_o(pv_a), .pred_take_o(pt_a), .pred_idx_o(pi_a),
    .upd_valid_i(upd_valid_i), .upd_idx_i(upd_idx_i), .upd_taken_i(upd_taken_i),
    .upd_pred_i(upd_pred_i), .flush_i(flush_i), .mispred_cnt_o(mc_a));

  br_predict_table #(.MODE(BP_BIMODAL), .STAT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i),
    .pred_valid_o(pv_b), .pred_take_o(pt_b), .pred_idx_o(pi_b),
    .upd_valid_i(upd_valid_i), .upd_idx_i(upd_idx_i), .upd_taken_i(upd_taken_i),
    .upd_pred_i(upd_pred_i), .flush_i(flush_i), .mispred_cnt_o(mc_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: 2-bit counters as plain integers, history as an integer.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) begin ca[i] = 3; cb[i] = 3; end
      ghr = 0; ev = 0; eta = 0; etb = 0; eia = 0; eib = 0; sa = 0; sb = 0;
    end else begin
      mib = int'((pred_pc_i >> 2) & 32'h3f);
      mia = mib ^ ghr;
      ev = pred_valid_i && !flush_i;
      if (ev) begin
        eta = (ca[mia] >= 2); etb = (cb[mib] >= 2); eia = mia; eib = mib;
      end
      if (upd_valid_i) begin
        if (upd_taken_i) begin
          if (ca[upd_idx_i] < 3) ca[upd_idx_i]++;
          if (cb[upd_idx_i] < 3) cb[upd_idx_i]++;
        end else begin
          if (ca[upd_idx_i] > 0) ca[upd_idx_i]--;
          if (cb[upd_idx_i] > 0) cb[upd_idx_i]--;
        end
        if (upd_pred_i != upd_taken_i) begin
          if (sa < 65535) sa++;
          if (sb < 3) sb++;
        end
      end
      if (flush_i) ghr = 0;
      else if (upd_valid_i) ghr = ((ghr << 1) | int'(upd_taken_i)) & 15;
    end
  end

  always @(negedge clk) if (rst_n) begin
    chk("valid_a", pv_a, ev);
    chk("valid_b", pv_b, ev);
    if (ev) begin
      chk("take_a", pt_a, eta);
      chk("take_b", pt_b, etb);
      chk("idx_a", pi_a, eia);
      chk("idx_b", pi_b, eib);
    end
    chk("mispred_a", mc_a, sa);
    chk("mispred_b", mc_b, sb);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic idle();
    pred_valid_i = 0; upd_valid_i = 0; flush_i = 0;
  endtask
  task automatic upd(input int idx, input bit taken, input bit pred);
    idle(); upd_valid_i = 1; upd_idx_i = 6'(idx); upd_taken_i = taken; upd_pred_i = pred;
    step(); idle();
  endtask
  task automatic look(input logic [31:0] pc);
    idle(); pred_valid_i = 1; pred_pc_i = pc; step(); idle();
  endtask

  initial begin
    bit exp_take[6];
    exp_take = '{1, 0, 0, 0, 0, 1};
    repeat (3) step();
    chk("rst_valid", pv_a, 0);
    chk("rst_take", pt_a, 0);
    chk("rst_idx", pi_a, 0);
    chk("rst_mispred", mc_a, 0);
    rst_n = 1;
    step();
    look(32'h100);
    chk("t1_valid", pv_a, 1);
    chk("t1_take", pt_a, 1);
    chk("t1_mispred", mc_a, 0);
    for (int i = 0; i < 6; i++) begin
      upd(0, i >= 4, i >= 4);
      look(32'h100);
      chk($sformatf("t2_take%0d", i), pt_b, exp_take[i]);
    end
    repeat (4) upd(10, 1, 1);
    look(32'h100);
    chk("t3_idx", pi_a, 6'h0f);
    upd(5, 0, 0);
    idle(); pred_valid_i = 1; pred_pc_i = 32'h14;
    upd_valid_i = 1; upd_idx_i = 6'd5; upd_taken_i = 0; upd_pred_i = 0;
    step(); idle();
    chk("t4_same", pt_b, 1);
    look(32'h14);
    chk("t4_after", pt_b, 0);
    pred_valid_i = 1; pred_pc_i = 32'h100; flush_i = 1;
    upd_valid_i = 1; upd_idx_i = 6'd5; upd_taken_i = 1; upd_pred_i = 1;
    step(); idle();
    chk("t5_valid_a", pv_a, 0);
    chk("t5_valid_b", pv_b, 0);
    look(32'h14);
    chk("t5_ghr_idx", pi_a, 6'd5);
    chk("t5_ctr", pt_b, 1);
    for (int i = 0; i < 5; i++) begin
      upd(30, 1, 0);
      chk($sformatf("t6_mis%0d", i), mc_b, (i < 3) ? i + 1 : 3);
    end
    upd(30, 1, 1);
    chk("t6_correct", mc_b, 3);
    chk("t6_mis_a", mc_a, 5);
    for (int n = 0; n < 2000; n++) begin
      if (n == 1500) begin
        #2 rst_n = 0;
        #1;
        chk("mid_rst_valid", pv_a, 0);
        chk("mid_rst_idx", pi_b, 0);
        chk("mid_rst_mis", mc_a, 0);
        @(posedge clk); #1 rst_n = 1;
      end
      pred_valid_i = 1'($urandom_range(0, 1));
      pred_pc_i = $urandom;
      upd_valid_i = 1'($urandom_range(0, 1));
      upd_idx_i = 6'($urandom_range(0, 63));
      upd_taken_i = 1'($urandom_range(0, 1));
      upd_pred_i = 1'($urandom_range(0, 1));
      flush_i = ($urandom_range(0, 15) == 0);
      step();
    end
    idle();
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
